rv_spi_target: RTL and testbench



---
 rtl/rv_pkg.sv | 13 +
 rtl/rv_sync_edge.sv | 33 +++
 rtl/rv_spi_target.sv | 231 +++++++++++++++++++++++
 tb/tb_rv_spi_target.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared types for the rv SPI target block.
// Holds the target FSM state type and the minimum clk/sck ratio.
package rv_pkg;

   typedef enum logic {
      SPI_TGT_IDLE,
      SPI_TGT_ACTIVE
   } spi_tgt_state_e;

   // f_clk must be at least this many times f_sck
   localparam int SPI_TGT_MIN_CLK_RATIO = 8;

endpackage

// File: rtl/rv_sync_edge.sv
// Multi-stage synchronizer with rise/fall detection on the synced level.
// Ports: clk_i, rst_i (sync, active-high), d_i (async in),
//        q_o (synced level), rise_o / fall_o (one-cycle edge pulses).
module rv_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              dly_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {STAGES{RST_VAL}};
         dly_q  <= RST_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         dly_q  <= sync_q[STAGES-1];
      end
   end

   assign q_o    = sync_q[STAGES-1];
   assign rise_o = sync_q[STAGES-1] & ~dly_q;
   assign fall_o = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/rv_spi_target.sv
// SPI mode-0 target, oversampled in clk_i; RX word strobe, TX holding reg.
// Build option: RV_SPI_TARGET_LSB_FIRST_EN selects LSB-first shifting.
// Ports: clk_i, rst_i (sync, active-high); spi_sck_i, spi_cs_n_i,
//   spi_mosi_i (async pins); spi_miso_o, spi_miso_oe_o (target out);
//   rx_data_o / rx_valid_o (received word + strobe);
//   tx_data_i / tx_valid_i / tx_ready_o (holding-register handshake);
//   tx_underrun_o, frame_abort_o (strobes); busy_o (frame active).
module rv_spi_target
   import rv_pkg::*;
#(
   parameter int          DATA_W      = 8,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] TX_IDLE     = 32'hFF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              spi_sck_i,
   input  logic              spi_cs_n_i,
   input  logic              spi_mosi_i,
   output logic              spi_miso_o,
   output logic              spi_miso_oe_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   output logic              tx_underrun_o,
   output logic              frame_abort_o,
   output logic              busy_o
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [DATA_W-1:0] IDLE_WORD = TX_IDLE[DATA_W-1:0];

   spi_tgt_state_e state_q, state_d;

   logic sck_lvl, sck_rise, sck_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic mosi_s, mosi_rise, mosi_fall;
   logic unused_lvl;

   logic [DATA_W-1:0] hold_q, hold_d;
   logic              full_q, full_d;
   logic [DATA_W-1:0] txsh_q, txsh_d;
   logic [DATA_W-1:0] rxsh_q, rxsh_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              under_q, under_d;
   logic              abort_q, abort_d;

   logic [DATA_W-1:0] rx_in;
   logic [DATA_W-1:0] tx_sh;
   logic              miso_bit;
   logic              act;
   logic              sck_ok;
   logic              end_frame;
   logic              load;

   rv_sync_edge #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b0)
   ) u_sck (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .d_i    (spi_sck_i),
      .q_o    (sck_lvl),
      .rise_o (sck_rise),
      .fall_o (sck_fall)
   );

   rv_sync_edge #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b1)
   ) u_cs (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .d_i    (spi_cs_n_i),
      .q_o    (cs_lvl),
      .rise_o (cs_rise),
      .fall_o (cs_fall)
   );

   rv_sync_edge #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b0)
   ) u_mosi (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .d_i    (spi_mosi_i),
      .q_o    (mosi_s),
      .rise_o (mosi_rise),
      .fall_o (mosi_fall)
   );

   // only edges matter for sck/cs, only the level for mosi
   assign unused_lvl = ^{sck_lvl, cs_lvl, mosi_rise, mosi_fall};

`ifdef RV_SPI_TARGET_LSB_FIRST_EN
   assign rx_in    = {mosi_s, rxsh_q[DATA_W-1:1]};
   assign tx_sh    = {1'b0, txsh_q[DATA_W-1:1]};
   assign miso_bit = txsh_q[0];
`else
   assign rx_in    = {rxsh_q[DATA_W-2:0], mosi_s};
   assign tx_sh    = {txsh_q[DATA_W-2:0], 1'b0};
   assign miso_bit = txsh_q[DATA_W-1];
`endif

   // FSM: state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= SPI_TGT_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SPI_TGT_IDLE:   if (cs_fall) state_d = SPI_TGT_ACTIVE;
         SPI_TGT_ACTIVE: if (cs_rise) state_d = SPI_TGT_IDLE;
         default:        state_d = SPI_TGT_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy_o        = (state_q == SPI_TGT_ACTIVE);
      spi_miso_oe_o = (state_q == SPI_TGT_ACTIVE);
   end

   assign act       = (state_q == SPI_TGT_ACTIVE);
   assign end_frame = act & cs_rise;
   // sck edges coinciding with deselect are dropped
   assign sck_ok    = act & ~cs_rise;
   assign load      = (~act & cs_fall) | (sck_ok & sck_fall & pend_q);

   always_comb begin
      hold_d     = hold_q;
      full_d     = full_q;
      txsh_d     = txsh_q;
      rxsh_d     = rxsh_q;
      cnt_d      = cnt_q;
      pend_d     = pend_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      under_d    = 1'b0;
      abort_d    = 1'b0;

      if (end_frame) begin
         abort_d = (cnt_q != '0);
         cnt_d   = '0;
         pend_d  = 1'b0;
         rxsh_d  = '0;
      end

      if (sck_ok & sck_rise) begin
         rxsh_d = rx_in;
         if (cnt_q == CNT_LAST) begin
            cnt_d      = '0;
            pend_d     = 1'b1;
            rx_data_d  = rx_in;
            rx_valid_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      if (sck_ok & sck_fall) begin
         if (pend_q) begin
            pend_d = 1'b0;
         end else begin
            txsh_d = tx_sh;
         end
      end

      if (load) begin
         if (full_q) begin
            txsh_d = hold_q;
            full_d = 1'b0;
         end else begin
            txsh_d  = IDLE_WORD;
            under_d = 1'b1;
         end
      end

      // a word accepted during a load waits for the next boundary
      if (tx_valid_i & ~full_q) begin
         hold_d = tx_data_i;
         full_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hold_q     <= '0;
         full_q     <= 1'b0;
         txsh_q     <= '0;
         rxsh_q     <= '0;
         cnt_q      <= '0;
         pend_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         under_q    <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         full_q     <= full_d;
         txsh_q     <= txsh_d;
         rxsh_q     <= rxsh_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         under_q    <= under_d;
         abort_q    <= abort_d;
      end
   end

   assign spi_miso_o    = miso_bit;
   assign rx_data_o     = rx_data_q;
   assign rx_valid_o    = rx_valid_q;
   assign tx_ready_o    = ~full_q;
   assign tx_underrun_o = under_q;
   assign frame_abort_o = abort_q;

endmodule

// File: tb/tb_rv_spi_target.sv
// Bench for rv_spi_target: SPI master driver plus word-level reference model.
// Honors RV_SPI_TARGET_LSB_FIRST_EN for bit order.
module tb_rv_spi_target;

   localparam int W  = 8;
   localparam int SS = 2;
   localparam logic [W-1:0] IDLE_W = 8'hFF;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sck = 1'b0;
   logic         cs_n = 1'b1;
   logic         mosi = 1'b0;
   logic         miso, miso_oe;
   logic [W-1:0] rx_data;
   logic         rx_valid;
   logic [W-1:0] tx_data = '0;
   logic         tx_valid = 1'b0;
   logic         tx_ready, under, abort, busy;

   always #5 clk = ~clk;

   rv_spi_target #(
      .DATA_W      (W),
      .SYNC_STAGES (SS),
      .TX_IDLE     (32'hFF)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .spi_sck_i     (sck),
      .spi_cs_n_i    (cs_n),
      .spi_mosi_i    (mosi),
      .spi_miso_o    (miso),
      .spi_miso_oe_o (miso_oe),
      .rx_data_o     (rx_data),
      .rx_valid_o    (rx_valid),
      .tx_data_i     (tx_data),
      .tx_valid_i    (tx_valid),
      .tx_ready_o    (tx_ready),
      .tx_underrun_o (under),
      .frame_abort_o (abort),
      .busy_o        (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model state
   logic [W-1:0] m_hold = '0;
   bit           m_full = 1'b0;
   logic [W-1:0] m_cur = '0;
   int           exp_under = 0;
   int           exp_abort = 0;
   int           dut_under = 0;
   int           dut_abort = 0;
   logic [W-1:0] rx_q[$];
   logic [W-1:0] rx_last = '0;

   logic [W-1:0] fr_mosi[8];
   logic [W-1:0] fr_miso[8];
   logic         first_bit;

   function automatic int bitpos(input int i);
`ifdef RV_SPI_TARGET_LSB_FIRST_EN
      return i;
`else
      return W - 1 - i;
`endif
   endfunction

   // word boundary: take the held word, else the idle pattern
   task automatic mload();
      if (m_full) begin
         m_cur  = m_hold;
         m_full = 1'b0;
      end else begin
         m_cur = IDLE_W;
         exp_under++;
      end
   endtask

   task automatic try_push(input bit want, input logic [W-1:0] d);
      bit acc;
      chk("tx_ready", tx_ready, !m_full);
      acc = want && !m_full;
      if (want) begin
         tx_valid = 1'b1;
         tx_data  = d;
      end
      @(negedge clk);
      tx_valid = 1'b0;
      if (acc) begin
         m_hold = d;
         m_full = 1'b1;
      end
   endtask

   // per-cycle compare against the model
   always @(posedge clk) begin
      #2;
      if (!rst) begin
         if (rx_valid) begin
            chk("rx_pending", rx_q.size() > 0, 1);
            if (rx_q.size() > 0) begin
               rx_last = rx_q.pop_front();
               chk("rx_data", rx_data, rx_last);
            end
         end else begin
            chk("rx_hold", rx_data, rx_last);
         end
         chk("oe_busy", miso_oe, busy);
         if (under) dut_under++;
         if (abort) dut_abort++;
      end
   end

   task automatic do_reset();
      rst  = 1'b1;
      cs_n = 1'b1;
      sck  = 1'b0;
      mosi = 1'b0;
      rx_q.delete();
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_oe", miso_oe, 0);
      chk("rst_ready", tx_ready, 1);
      chk("rst_rxdata", rx_data, 0);
      chk("rst_miso", miso, 0);
      m_full  = 1'b0;
      rx_last = '0;
      rst     = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   // one cs-low frame; final sck fall coincides with cs rise
   task automatic frame(input int nbits, input bit pushes,
                        input int hs_word, input int rst_at);
      int w, i;
      bit was_full;
      logic [W-1:0] acc;
      acc = '0;
      for (int k = 0; k < 8; k++) fr_miso[k] = '0;
      @(negedge clk);
      cs_n = 1'b0;
      mosi = fr_mosi[0][bitpos(0)];
      mload();
      repeat (4) @(negedge clk);
      for (int b = 0; b < nbits; b++) begin
         w = b / W;
         i = b % W;
         chk("miso_bit", miso, m_cur[bitpos(i)]);
         fr_miso[w][bitpos(i)] = miso;
         if (b == 0) first_bit = miso;
         sck = 1'b1;
         acc[bitpos(i)] = mosi;
         if (i == W - 1) rx_q.push_back(acc);
         if (b == rst_at) begin
            do_reset();
            return;
         end
         repeat (2) @(negedge clk);
         try_push(pushes && i == 2 && ($urandom % 2 == 1), W'($urandom));
         @(negedge clk);
         if (b == nbits - 1) begin
            sck  = 1'b0;
            cs_n = 1'b1;
            if (nbits % W != 0) exp_abort++;
         end else begin
            sck  = 1'b0;
            mosi = fr_mosi[(b + 1) / W][bitpos((b + 1) % W)];
            if ((b + 1) % W == 0) begin
               if ((b + 1) / W == hs_word) begin
                  repeat (SS) @(negedge clk);
                  chk("hs_ready", tx_ready, !m_full);
                  was_full = m_full;
                  tx_valid = 1'b1;
                  tx_data  = 8'h77;
                  @(negedge clk);
                  tx_valid = 1'b0;
                  mload();
                  if (!was_full) begin
                     m_hold = 8'h77;
                     m_full = 1'b1;
                  end
                  @(negedge clk);
               end else begin
                  mload();
                  repeat (4) @(negedge clk);
               end
            end else begin
               repeat (4) @(negedge clk);
            end
         end
      end
      repeat (10) @(negedge clk);
      chk("underruns", dut_under, exp_under);
      chk("aborts", dut_abort, exp_abort);
      chk("rx_drained", rx_q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int u0, a0, nb;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_oe", miso_oe, 0);
      chk("reset_ready", tx_ready, 1);
      chk("reset_rxdata", rx_data, 0);
      chk("reset_rxvalid", rx_valid, 0);
      chk("reset_under", under, 0);
      chk("reset_abort", abort, 0);
      chk("reset_miso", miso, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // single word, held A5, receive 3C
      try_push(1'b1, 8'hA5);
      repeat (3) @(negedge clk);
      fr_mosi[0] = 8'h3C;
      frame(8, 1'b0, -1, -1);
      chk("t1_miso", fr_miso[0], 8'hA5);
      chk("t1_rx", rx_data, 8'h3C);
      chk("t1_ready", tx_ready, 1);

      // two words, only 11 held
      try_push(1'b1, 8'h11);
      repeat (3) @(negedge clk);
      u0 = dut_under;
      fr_mosi[0] = W'($urandom);
      fr_mosi[1] = W'($urandom);
      frame(16, 1'b0, -1, -1);
      chk("t2_w0", fr_miso[0], 8'h11);
      chk("t2_w1", fr_miso[1], 8'hFF);
      chk("t2_under", dut_under - u0, 1);

      // handshake of 77 on the second-word load boundary
      try_push(1'b1, 8'h5A);
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) fr_mosi[k] = W'($urandom);
      frame(24, 1'b0, 1, -1);
      chk("t3_w0", fr_miso[0], 8'h5A);
      chk("t3_w1", fr_miso[1], 8'hFF);
      chk("t3_w2", fr_miso[2], 8'h77);

      // partial word abort, then a clean frame
      a0 = dut_abort;
      fr_mosi[0] = W'($urandom);
      frame(5, 1'b0, -1, -1);
      chk("t4_abort", dut_abort - a0, 1);
      try_push(1'b1, 8'hC3);
      repeat (3) @(negedge clk);
      fr_mosi[0] = 8'h96;
      frame(8, 1'b0, -1, -1);
      chk("t4_rx", rx_data, 8'h96);
      chk("t4_miso", fr_miso[0], 8'hC3);

      // reset after bit 3, then normal frame
      try_push(1'b1, 8'hE1);
      repeat (3) @(negedge clk);
      fr_mosi[0] = 8'hF0;
      frame(8, 1'b0, -1, 3);
      try_push(1'b1, 8'h5C);
      repeat (3) @(negedge clk);
      fr_mosi[0] = 8'h2B;
      frame(8, 1'b0, -1, -1);
      chk("t5_rx", rx_data, 8'h2B);
      chk("t5_miso", fr_miso[0], 8'h5C);

`ifdef RV_SPI_TARGET_LSB_FIRST_EN
      try_push(1'b1, 8'h01);
      repeat (3) @(negedge clk);
      fr_mosi[0] = 8'h3C;
      frame(8, 1'b0, -1, -1);
      chk("t6_rx", rx_data, 8'h3C);
      chk("t6_first", first_bit, 1);
`endif

      // randomized frames
      for (int n = 0; n < 40; n++) begin
         try_push($urandom % 2 == 1, W'($urandom));
         repeat (3) @(negedge clk);
         for (int k = 0; k < 8; k++) fr_mosi[k] = W'($urandom);
         if ($urandom % 5 == 0) nb = $urandom_range(1, 3 * W);
         else nb = W * $urandom_range(1, 4);
         frame(nb, 1'b1, -1, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
